// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 DIT FFT stage sequencer.
// Contents:
//   state_t        - sequencer states (IDLE, ISSUE, DRAIN, DONE)
//   DEFAULT_*      - default transform size and butterfly pipeline depth
//   bf_addr_t      - operand addresses and twiddle index of one butterfly,
//                    sized for the largest supported transform
//   calcBfAddr     - (stage, butterfly) -> {addrA, addrB, twIdx}
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_N_LOG2   = 3;
  localparam int DEFAULT_PIPE_LAT = 2;
  localparam int MAX_N_LOG2       = 10;

  typedef struct packed {
    logic [MAX_N_LOG2-1:0] addrA;
    logic [MAX_N_LOG2-1:0] addrB;
    logic [MAX_N_LOG2-1:0] twIdx;
  } bf_addr_t;

  // Butterfly k of stage s pairs points that are 2^s apart. Butterflies are
  // grouped in runs of 2^s; each group occupies 2^(s+1) consecutive points.
  // The twiddle exponent is the position inside the group, scaled so that
  // every stage indexes one shared N/2-entry ROM.
  function automatic bf_addr_t calcBfAddr(input int unsigned nLog2,
                                          input int unsigned s,
                                          input int unsigned k);
    int unsigned span;
    int unsigned pos;
    int unsigned grp;
    int unsigned a;
    bf_addr_t    res;
    span      = 32'd1 << s;
    pos       = k & (span - 32'd1);
    grp       = k >> s;
    a         = (grp << (s + 32'd1)) + pos;
    res.addrA = MAX_N_LOG2'(a);
    res.addrB = MAX_N_LOG2'(a + span);
    res.twIdx = MAX_N_LOG2'(pos << (nLog2 - 32'd1 - s));
    return res;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Combinational butterfly address generator.
// Ports:
//   i_stage   - stage number s
//   i_bf_idx  - butterfly index k within the stage (0 .. N/2-1)
//   o_addr_a  - upper-wing operand address
//   o_addr_b  - lower-wing operand address (o_addr_a + 2^s)
//   o_tw_idx  - twiddle ROM index
module fft_bf_addr_gen
  import fft_pkg::*;
#(
  parameter int N_LOG2  = DEFAULT_N_LOG2,
  parameter int STAGE_W = 2
) (
  input  logic [STAGE_W-1:0] i_stage,
  input  logic [N_LOG2-2:0]  i_bf_idx,
  output logic [N_LOG2-1:0]  o_addr_a,
  output logic [N_LOG2-1:0]  o_addr_b,
  output logic [N_LOG2-2:0]  o_tw_idx
);

  bf_addr_t w_res;

  // The shared helper works at the widest supported size; the results always
  // fit this instance's port widths, so truncation loses nothing.
  assign w_res    = calcBfAddr(N_LOG2, 32'(i_stage), 32'(i_bf_idx));
  assign o_addr_a = N_LOG2'(w_res.addrA);
  assign o_addr_b = N_LOG2'(w_res.addrB);
  assign o_tw_idx = (N_LOG2 - 1)'(w_res.twIdx);

endmodule

// File: rtl/fft_stage_sequencer.sv
// Control sequencer for a radix-2 decimation-in-time FFT datapath.
// Walks every stage and butterfly, issuing operand addresses and a twiddle
// index over a valid/ready handshake, with a drain gap of PIPE_LAT cycles
// between stages so write-back completes before the next stage reads.
// Ports:
//   clk, reset   - clock, synchronous active-low reset
//   i_start      - begin a transform (accepted only in IDLE)
//   i_abort      - cancel the current transform, no done pulse
//   i_bf_ready   - butterfly unit accepts the current issue
//   o_bf_valid   - address/twiddle outputs are valid
//   o_addr_a/b   - operand addresses
//   o_tw_idx     - twiddle ROM index
//   o_stage      - current stage number
//   o_bf_last    - final butterfly of the final stage
//   o_busy       - sequencer not idle
//   o_done       - one-cycle completion pulse
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2   = DEFAULT_N_LOG2,
  parameter int PIPE_LAT = DEFAULT_PIPE_LAT,
  localparam int STAGE_W = (N_LOG2 < 2) ? 1 : $clog2(N_LOG2)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic                i_bf_ready,
  output logic                o_bf_valid,
  output logic [N_LOG2-1:0]   o_addr_a,
  output logic [N_LOG2-1:0]   o_addr_b,
  output logic [N_LOG2-2:0]   o_tw_idx,
  output logic [STAGE_W-1:0]  o_stage,
  output logic                o_bf_last,
  output logic                o_busy,
  output logic                o_done
);

  localparam int KW = N_LOG2 - 1;
  localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [KW-1:0]      K_LAST = KW'((1 << KW) - 1);
  localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(N_LOG2 - 1);
  localparam logic [DW-1:0]      D_INIT = DW'(PIPE_LAT - 1);

  state_t               r_state;
  state_t               w_nextState;
  logic [STAGE_W-1:0]   r_stage;
  logic [STAGE_W-1:0]   w_nextStage;
  logic [KW-1:0]        r_bfIdx;
  logic [KW-1:0]        w_nextBfIdx;
  logic [DW-1:0]        r_drainCnt;
  logic [DW-1:0]        w_nextDrainCnt;
  logic                 w_issueNext;
  logic [N_LOG2-1:0]    w_addrA;
  logic [N_LOG2-1:0]    w_addrB;
  logic [N_LOG2-2:0]    w_twIdx;

  // Next-state logic. Counters are only cleared on the way back to IDLE so a
  // stalled issue keeps its (stage, k) and therefore its outputs unchanged.
  // Abort overrides everything, including a simultaneous start.
  always_comb begin
    w_nextState    = r_state;
    w_nextStage    = r_stage;
    w_nextBfIdx    = r_bfIdx;
    w_nextDrainCnt = r_drainCnt;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_nextState = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (o_bf_valid && i_bf_ready) begin
          if (r_bfIdx != K_LAST) begin
            w_nextBfIdx = r_bfIdx + 1'b1;
          end else begin
            w_nextState    = ST_DRAIN;
            w_nextDrainCnt = D_INIT;
          end
        end
      end
      ST_DRAIN: begin
        if (r_drainCnt != '0) begin
          w_nextDrainCnt = r_drainCnt - 1'b1;
        end else if (r_stage != S_LAST) begin
          w_nextState = ST_ISSUE;
          w_nextStage = r_stage + 1'b1;
          w_nextBfIdx = '0;
        end else begin
          w_nextState = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
    if (i_abort) begin
      w_nextState = ST_IDLE;
    end
    if (w_nextState == ST_IDLE) begin
      w_nextStage    = '0;
      w_nextBfIdx    = '0;
      w_nextDrainCnt = '0;
    end
  end

  assign w_issueNext = (w_nextState == ST_ISSUE);

  // Addresses are computed from the next (stage, k) so the registered
  // outputs line up with the state they describe.
  fft_bf_addr_gen #(
    .N_LOG2  (N_LOG2),
    .STAGE_W (STAGE_W)
  ) u_addrGen (
    .i_stage  (w_nextStage),
    .i_bf_idx (w_nextBfIdx),
    .o_addr_a (w_addrA),
    .o_addr_b (w_addrB),
    .o_tw_idx (w_twIdx)
  );

  // State, counters and every output are registered here. Address outputs
  // read as zero whenever no issue is presented.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_stage    <= '0;
      r_bfIdx    <= '0;
      r_drainCnt <= '0;
      o_bf_valid <= 1'b0;
      o_addr_a   <= '0;
      o_addr_b   <= '0;
      o_tw_idx   <= '0;
      o_stage    <= '0;
      o_bf_last  <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_stage    <= w_nextStage;
      r_bfIdx    <= w_nextBfIdx;
      r_drainCnt <= w_nextDrainCnt;
      o_bf_valid <= w_issueNext;
      o_addr_a   <= w_issueNext ? w_addrA : '0;
      o_addr_b   <= w_issueNext ? w_addrB : '0;
      o_tw_idx   <= w_issueNext ? w_twIdx : '0;
      o_stage    <= w_nextStage;
      o_bf_last  <= w_issueNext && (w_nextStage == S_LAST) && (w_nextBfIdx == K_LAST);
      o_busy     <= (w_nextState != ST_IDLE);
      o_done     <= (w_nextState == ST_DONE);
    end
  end

endmodule
